// File: rtl/muladd_resp_checker.sv
// Response checker for the fused multiply-add pipeline (y = a*b + c).
// Build option: define MULADD_CHK_FIRST_FAIL_EN to capture the first failure.
module muladd_resp_checker #(
    parameter int AW     = 8,
    parameter int CW     = 16,
    parameter int LAT    = 2,
    parameter int WARMUP = 4995,
    parameter int NCHECK = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] a,
    input  logic [AW-1:0] b,
    input  logic [CW-1:0] c,
    input  logic          en,
    input  logic [CW-1:0] y,
    output logic          mismatch,
    output logic [15:0]   err_count,
    output logic [15:0]   chk_count,
    output logic          done,
    output logic          pass,
    output logic [CW-1:0] first_exp,
    output logic [CW-1:0] first_got
);

    localparam int WCW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

    typedef enum logic [1:0] {WARM, FILL, CHECK, DONE} state_t;

    state_t           state_q, state_d;
    logic [WCW-1:0]   wcnt_q, wcnt_d;
    logic [LAT-1:0]   vld_q, vld_d;
    logic [CW-1:0]    val_q [LAT];
    logic [CW-1:0]    val_d [LAT];
    logic             adv_q, adv_d;
    logic             mismatch_q, mismatch_d;
    logic [15:0]      err_q, err_d;
    logic [15:0]      chk_q, chk_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    logic signed [2*AW-1:0] a_x, b_x, prod;
    logic [2*AW+CW-1:0]     prod_x;
    logic [CW-1:0]          gold;
    logic                   cmp_en;
    logic                   bad;

    // Golden value: full signed product fitted to CW, then addend mod 2^CW
    always_comb begin
        a_x    = {{AW{a[AW-1]}}, a};
        b_x    = {{AW{b[AW-1]}}, b};
        prod   = a_x * b_x;
        prod_x = {{CW{prod[2*AW-1]}}, prod};
        gold   = prod_x[CW-1:0] + c;
    end

    assign cmp_en = adv_q && vld_q[LAT-1] &&
                    (state_q == FILL || state_q == CHECK);
    assign bad    = cmp_en && (y != val_q[LAT-1]);

    // Next-state: golden pipeline, warm-up FSM, compare bookkeeping
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        vld_d      = vld_q;
        val_d      = val_q;
        adv_d      = en;
        mismatch_d = 1'b0;
        err_d      = err_q;
        chk_d      = chk_q;
        if (en) begin
            vld_d[0] = 1'b1;
            val_d[0] = gold;
            for (int i = 1; i < LAT; i++) begin
                vld_d[i] = vld_q[i-1];
                val_d[i] = val_q[i-1];
            end
        end
        unique case (state_q)
            WARM: begin
                if (wcnt_q == WCW'(WARMUP - 1)) begin
                    state_d = FILL;
                    vld_d   = '0;
                end else begin
                    wcnt_d = wcnt_q + WCW'(1);
                end
            end
            FILL: begin
                if (vld_q[LAT-1]) state_d = CHECK;
            end
            CHECK: begin
            end
            DONE: begin
            end
        endcase
        if (cmp_en) begin
            chk_d = chk_q + 16'd1;
            if (bad) begin
                mismatch_d = 1'b1;
                if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            end
            if (chk_d == 16'(NCHECK)) state_d = DONE;
        end
        done_d = done_q | (state_q == DONE);
        pass_d = done_d & (err_q == 16'd0);
    end

    // State and status registers, synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= WARM;
            wcnt_q     <= '0;
            vld_q      <= '0;
            val_q      <= '{default: '0};
            adv_q      <= 1'b0;
            mismatch_q <= 1'b0;
            err_q      <= '0;
            chk_q      <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            vld_q      <= vld_d;
            val_q      <= val_d;
            adv_q      <= adv_d;
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
            chk_q      <= chk_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    assign mismatch  = mismatch_q;
    assign err_count = err_q;
    assign chk_count = chk_q;
    assign done      = done_q;
    assign pass      = pass_q;

`ifdef MULADD_CHK_FIRST_FAIL_EN
    logic          seen_q, seen_d;
    logic [CW-1:0] fexp_q, fexp_d;
    logic [CW-1:0] fgot_q, fgot_d;

    // Capture expected/actual of the first failing compare only
    always_comb begin
        seen_d = seen_q;
        fexp_d = fexp_q;
        fgot_d = fgot_q;
        if (bad && !seen_q) begin
            seen_d = 1'b1;
            fexp_d = val_q[LAT-1];
            fgot_d = y;
        end
    end

    // First-failure capture registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            seen_q <= 1'b0;
            fexp_q <= '0;
            fgot_q <= '0;
        end else begin
            seen_q <= seen_d;
            fexp_q <= fexp_d;
            fgot_q <= fgot_d;
        end
    end

    assign first_exp = fexp_q;
    assign first_got = fgot_q;
`else
    assign first_exp = '0;
    assign first_got = '0;
`endif

endmodule

// File: tb/tb_muladd_resp_checker.sv
// Directed bench for muladd_resp_checker with a 2-stage reference DUT model.
// Honours MULADD_CHK_FIRST_FAIL_EN when checking first_exp/first_got.
module tb_muladd_resp_checker;

    localparam int AW     = 8;
    localparam int CW     = 16;
    localparam int LAT    = 2;
    localparam int WARMUP = 10;
    localparam int NCHECK = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] a = '0;
    logic [AW-1:0] b = '0;
    logic [CW-1:0] c = '0;
    logic          en = 1'b0;
    logic [CW-1:0] y;
    logic          mismatch;
    logic [15:0]   err_count;
    logic [15:0]   chk_count;
    logic          done;
    logic          pass;
    logic [CW-1:0] first_exp;
    logic [CW-1:0] first_got;

    muladd_resp_checker #(
        .AW(AW), .CW(CW), .LAT(LAT), .WARMUP(WARMUP), .NCHECK(NCHECK)
    ) dut (
        .clock(clock), .reset(reset), .a(a), .b(b), .c(c), .en(en),
        .y(y), .mismatch(mismatch), .err_count(err_count),
        .chk_count(chk_count), .done(done), .pass(pass),
        .first_exp(first_exp), .first_got(first_got)
    );

    always #5 clock = ~clock;

    // Reference DUT configuration
    bit            use_model = 1'b0;
    bit            vary = 1'b0;
    bit            tog = 1'b0;
    bit            corrupt = 1'b0;
    bit            wbad = 1'b0;
    logic [CW-1:0] y_const = '0;
    logic [CW-1:0] r1 = '0;
    logic [CW-1:0] r2 = '0;
    int            cyc = 0;
    int            pulses = 0;
    int            ph = 0;
    int            nchk = 0;
    int            nerr = 0;

    function automatic logic [CW-1:0] ref_fma(input logic [AW-1:0] ia,
                                              input logic [AW-1:0] ib,
                                              input logic [CW-1:0] ic);
        int p;
        p = int'($signed(ia)) * int'($signed(ib)) + int'(ic);
        return CW'(p);
    endfunction

    // Ideal 2-stage pipelined DUT holding on en=0
    always @(posedge clock) begin
        if (en) begin
            r1 <= ref_fma(a, b, c);
            r2 <= r1;
        end
    end

    // Cycles since reset release
    always @(posedge clock) begin
        if (!reset) cyc <= 0;
        else cyc <= cyc + 1;
    end

    // DUT output with optional fault injection
    always_comb begin
        y = use_model ? r2 : y_const;
        if (corrupt) y = y ^ 16'h0001;
        if (wbad && cyc < WARMUP) y = ~y;
    end

    task automatic check(input string name, input int got, input int exp);
        nchk++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        if (mismatch) pulses++;
        if (vary) begin
            a = AW'($urandom);
            b = AW'($urandom);
            c = CW'($urandom);
        end
        if (tog) begin
            en = (ph == 0);
            ph = (ph == 2) ? 0 : ph + 1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        pulses = 0;
        ph = 0;
        step();
        step();
        check("rst_chk_count", int'(chk_count), 0);
        check("rst_err_count", int'(err_count), 0);
        check("rst_done", int'(done), 0);
        check("rst_pass_mism", int'({pass, mismatch}), 0);
        reset = 1'b1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 400) begin
            step();
            n++;
        end
        check("done_seen", int'(done), 1);
    endtask

    typedef struct {
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [CW-1:0] c;
        logic [CW-1:0] yc;
        bit            model;
        bit            vary;
        bit            tog;
        bit            corrupt;
        bit            wbad;
        int            exp_err;
        bit            exp_pass;
        int            exp_pulses;
        bit            cf;
        logic [CW-1:0] fe;
        logic [CW-1:0] fg;
    } vec_t;

    vec_t vt[10];

    initial begin
        int n;
        vt[0] = '{8'd8,   8'd2,   16'd3,      16'd19,     0,0,0,0,0, 0,1,0, 1,16'd0,16'd0};
        vt[1] = '{8'd8,   8'd2,   16'd3,      16'd18,     0,0,0,0,0, 4,0,4, 1,16'd19,16'd18};
        vt[2] = '{8'h80,  8'h80,  16'hFFFF,   16'd16383,  0,0,0,0,0, 0,1,0, 0,16'd0,16'd0};
        vt[3] = '{8'h80,  8'h80,  16'h0000,   16'd16384,  0,0,0,0,0, 0,1,0, 0,16'd0,16'd0};
        vt[4] = '{8'h7F,  8'h80,  16'd100,    16'hC0E4,   0,0,0,0,0, 0,1,0, 0,16'd0,16'd0};
        vt[5] = '{8'hFF,  8'h01,  16'h0000,   16'hFFFF,   0,0,0,0,0, 0,1,0, 0,16'd0,16'd0};
        vt[6] = '{8'd0,   8'd0,   16'd0,      16'd0,      1,1,0,0,0, 0,1,0, 0,16'd0,16'd0};
        vt[7] = '{8'd0,   8'd0,   16'd0,      16'd0,      1,1,1,0,0, 0,1,0, 0,16'd0,16'd0};
        vt[8] = '{8'd0,   8'd0,   16'd0,      16'd0,      1,1,0,0,1, 0,1,0, 0,16'd0,16'd0};
        vt[9] = '{8'd0,   8'd0,   16'd0,      16'd0,      1,1,0,1,0, 4,0,4, 0,16'd0,16'd0};

        for (int i = 0; i < 10; i++) begin
            a = vt[i].a;
            b = vt[i].b;
            c = vt[i].c;
            y_const = vt[i].yc;
            use_model = vt[i].model;
            vary = vt[i].vary;
            tog = vt[i].tog;
            corrupt = vt[i].corrupt;
            wbad = vt[i].wbad;
            en = 1'b1;
            do_reset();
            wait_done(n);
            if (!vt[i].tog) begin
                check("done_latency_lo", int'(n >= WARMUP + LAT + NCHECK), 1);
                check("done_latency_hi", int'(n <= WARMUP + LAT + NCHECK + 3), 1);
            end
            check("chk_count_final", int'(chk_count), NCHECK);
            check("err_count_final", int'(err_count), vt[i].exp_err);
            check("pass_final", int'(pass), int'(vt[i].exp_pass));
            check("mismatch_pulses", pulses, vt[i].exp_pulses);
`ifdef MULADD_CHK_FIRST_FAIL_EN
            if (vt[i].cf) begin
                check("first_exp", int'(first_exp), int'(vt[i].fe));
                check("first_got", int'(first_got), int'(vt[i].fg));
            end
`else
            if (vt[i].cf) begin
                check("first_exp_tied", int'(first_exp), 0);
                check("first_got_tied", int'(first_got), 0);
            end
`endif
            repeat (6) step();
            check("chk_count_frozen", int'(chk_count), NCHECK);
            check("pulses_frozen", pulses, vt[i].exp_pulses);
            check("done_sticky", int'(done), 1);
        end

        // en held low mid-CHECK: only the in-flight compare completes
        use_model = 1'b1;
        vary = 1'b1;
        tog = 1'b0;
        corrupt = 1'b0;
        wbad = 1'b0;
        en = 1'b1;
        do_reset();
        n = 0;
        while (chk_count != 16'd1 && n < 100) begin
            step();
            n++;
        end
        check("hold_reach_1", int'(chk_count), 1);
        en = 1'b0;
        repeat (5) step();
        check("hold_chk_2", int'(chk_count), 2);
        en = 1'b1;
        step();
        en = 1'b0;
        repeat (4) step();
        check("hold_one_adv", int'(chk_count), 3);
        check("hold_no_err", int'(err_count), 0);
        en = 1'b1;
        wait_done(n);
        check("hold_pass", int'(pass), 1);

        // Reset pulse mid-CHECK restarts the whole warm-up
        use_model = 1'b0;
        vary = 1'b0;
        a = 8'd8;
        b = 8'd2;
        c = 16'd3;
        y_const = 16'd19;
        en = 1'b1;
        do_reset();
        n = 0;
        while (chk_count != 16'd2 && n < 100) begin
            step();
            n++;
        end
        check("mid_reach_2", int'(chk_count), 2);
        reset = 1'b0;
        step();
        check("mid_rst_chk", int'(chk_count), 0);
        check("mid_rst_err_done", int'({err_count, done}), 0);
        reset = 1'b1;
        repeat (WARMUP + LAT) step();
        check("mid_rewarm_chk", int'(chk_count), 0);
        wait_done(n);
        check("mid_final_chk", int'(chk_count), NCHECK);
        check("mid_final_pass", int'(pass), 1);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
